// File: rtl/serial_subtractor.sv
// Digit-serial subtractor D = A - B, DIGIT bits per cycle with a registered borrow chain.
// Define SUB_ABS_EN to add the NEG pass that returns |A - B| and flags Swap.
module serial_subtractor #(
   parameter int WIDTH = 32,
   parameter int DIGIT = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             ready,
   output logic             done,
   output logic [WIDTH-1:0] D,
   output logic             Bout,
   output logic             Zero,
   output logic             Swap
);

   localparam int K  = WIDTH / DIGIT;
   localparam int CW = (K > 1) ? $clog2(K) : 1;

`ifdef SUB_ABS_EN
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_SUB = 2'd1, S_NEG = 2'd2} state_t;
`else
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_SUB = 2'd1} state_t;
`endif

   state_t            state_q;
   logic [WIDTH-1:0]  a_q;
   logic [WIDTH-1:0]  b_q;
   logic [WIDTH-1:0]  res_q;
   logic              brw_q;
   logic [CW-1:0]     cnt_q;
   logic              ready_q;
   logic              done_q;
   logic [WIDTH-1:0]  d_q;
   logic              bout_q;
   logic              zero_q;
   logic              swap_q;

   logic [DIGIT:0]       dig_d;
   logic [WIDTH+DIGIT-1:0] res_cat_s;
   logic [WIDTH-1:0]     res_d;
   logic                 last_s;

   // One digit step: the top bit of the (DIGIT+1)-bit difference is the outgoing borrow.
   always_comb begin
      dig_d     = {1'b0, a_q[DIGIT-1:0]} - {1'b0, b_q[DIGIT-1:0]} - {{DIGIT{1'b0}}, brw_q};
      res_cat_s = {dig_d[DIGIT-1:0], res_q};
      res_d     = res_cat_s[WIDTH+DIGIT-1:DIGIT];
      last_s    = (cnt_q == CW'(K - 1));
   end

   // Control FSM, datapath shift registers and registered results.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         a_q     <= {WIDTH{1'b0}};
         b_q     <= {WIDTH{1'b0}};
         res_q   <= {WIDTH{1'b0}};
         brw_q   <= 1'b0;
         cnt_q   <= {CW{1'b0}};
         ready_q <= 1'b1;
         done_q  <= 1'b0;
         d_q     <= {WIDTH{1'b0}};
         bout_q  <= 1'b0;
         zero_q  <= 1'b1;
         swap_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  a_q     <= A;
                  b_q     <= B;
                  brw_q   <= 1'b0;
                  cnt_q   <= {CW{1'b0}};
                  ready_q <= 1'b0;
                  state_q <= S_SUB;
               end else begin
                  ready_q <= 1'b1;
               end
            end
            S_SUB: begin
               a_q   <= a_q >> DIGIT;
               b_q   <= b_q >> DIGIT;
               res_q <= res_d;
               brw_q <= dig_d[DIGIT];
               cnt_q <= cnt_q + 1'b1;
               if (last_s) begin
`ifdef SUB_ABS_EN
                  if (dig_d[DIGIT]) begin
                     // Negate the wrapped difference: 0 - (A - B) = B - A.
                     state_q <= S_NEG;
                     a_q     <= {WIDTH{1'b0}};
                     b_q     <= res_d;
                     brw_q   <= 1'b0;
                     cnt_q   <= {CW{1'b0}};
                  end else begin
                     d_q     <= res_d;
                     bout_q  <= 1'b0;
                     zero_q  <= (res_d == {WIDTH{1'b0}});
                     swap_q  <= 1'b0;
                     done_q  <= 1'b1;
                     ready_q <= 1'b1;
                     state_q <= S_IDLE;
                  end
`else
                  d_q     <= res_d;
                  bout_q  <= dig_d[DIGIT];
                  zero_q  <= (res_d == {WIDTH{1'b0}});
                  swap_q  <= 1'b0;
                  done_q  <= 1'b1;
                  ready_q <= 1'b1;
                  state_q <= S_IDLE;
`endif
               end
            end
`ifdef SUB_ABS_EN
            S_NEG: begin
               a_q   <= a_q >> DIGIT;
               b_q   <= b_q >> DIGIT;
               res_q <= res_d;
               brw_q <= dig_d[DIGIT];
               cnt_q <= cnt_q + 1'b1;
               if (last_s) begin
                  d_q     <= res_d;
                  bout_q  <= 1'b1;
                  zero_q  <= (res_d == {WIDTH{1'b0}});
                  swap_q  <= 1'b1;
                  done_q  <= 1'b1;
                  ready_q <= 1'b1;
                  state_q <= S_IDLE;
               end
            end
`endif
            default: begin
               state_q <= S_IDLE;
               ready_q <= 1'b1;
            end
         endcase
      end
   end

   assign ready = ready_q;
   assign done  = done_q;
   assign D     = d_q;
   assign Bout  = bout_q;
   assign Zero  = zero_q;
   assign Swap  = swap_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=32, DIGIT=8); honours SUB_ABS_EN.
module tb_serial_subtractor;

   localparam int WIDTH = 32;
   localparam int DIGIT = 8;
   localparam int K     = WIDTH / DIGIT;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b0;
   logic [WIDTH-1:0] a_in = '0;
   logic [WIDTH-1:0] b_in = '0;
   logic             ready, done, bout, zero, swap;
   logic [WIDTH-1:0] d_out;

   int n_vec   = 0;
   int n_check = 0;
   int n_fail  = 0;

   serial_subtractor #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .A(a_in), .B(b_in),
      .ready(ready), .done(done), .D(d_out), .Bout(bout), .Zero(zero), .Swap(swap)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
      n_check++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference: plain arithmetic on the operands.
   task automatic model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        output logic [WIDTH-1:0] ed, output logic eb, output logic ez,
                        output logic es, output int el);
      eb = (a < b);
      ed = a - b;
      es = 1'b0;
      el = K;
`ifdef SUB_ABS_EN
      if (eb) begin
         ed = b - a;
         es = 1'b1;
         el = 2 * K;
      end
`endif
      ez = (ed == '0);
   endtask

   task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      logic [WIDTH-1:0] ed;
      logic eb, ez, es;
      int el, cyc;
      logic seen;
      model(a, b, ed, eb, ez, es, el);
      a_in  = a;
      b_in  = b;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("ready_low", ready, 0);
      cyc  = 0;
      seen = 1'b0;
      while (!seen && cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
         if (done) seen = 1'b1;
      end
      check("done_seen", seen, 1);
      check("latency", cyc, el);
      check("D", d_out, ed);
      check("Bout", bout, eb);
      check("Zero", zero, ez);
      check("Swap", swap, es);
      check("ready_done", ready, 1);
      @(posedge clk); #1;
      check("done_width", done, 0);
      n_vec++;
   endtask

   initial begin
      int cyc, ndone, extra, last, gap_bad;
      logic [WIDTH-1:0] ra, rb;

      // Reset state
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ready", ready, 1);
      check("rst_done", done, 0);
      check("rst_D", d_out, 0);
      check("rst_Bout", bout, 0);
      check("rst_Zero", zero, 1);
      check("rst_Swap", swap, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Directed cases
      do_op(32'h0000_0005, 32'h0000_0003);
      do_op(32'h0000_0003, 32'h0000_0005);
      do_op(32'h0001_0000, 32'h0000_0001);
      do_op(32'h1234_5678, 32'h1234_5678);
      do_op(32'h0000_0000, 32'h0000_0001);
      do_op(32'hFFFF_FFFF, 32'h0000_0000);

      // start pulsed during SUB is ignored
      a_in = 32'd5; b_in = 32'd3; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      a_in = 32'd100; b_in = 32'd1; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      cyc = 2; ndone = 0;
      while (ndone == 0 && cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
         if (done) ndone++;
      end
      check("ign_latency", cyc, K);
      check("ign_D", d_out, 32'd2);
      extra = 0;
      repeat (12) begin
         @(posedge clk); #1;
         if (done) extra++;
      end
      check("ign_one_done", extra, 0);
      check("ign_ready", ready, 1);
      n_vec++;

      // Reset at digit 2 drops the operation
      a_in = 32'h1111_2222; b_in = 32'h0000_0001; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      check("mrst_done", done, 0);
      check("mrst_ready", ready, 1);
      check("mrst_D", d_out, 0);
      check("mrst_Bout", bout, 0);
      check("mrst_Zero", zero, 1);
      check("mrst_Swap", swap, 0);
      extra = 0;
      repeat (10) begin
         @(posedge clk); #1;
         if (done) extra++;
      end
      check("mrst_no_done", extra, 0);
      do_op(32'h0000_1000, 32'h0000_0FFF);

      // Back-to-back with start held high
      a_in = 32'd9; b_in = 32'd4; start = 1'b1;
      ndone = 0; last = -1; gap_bad = 0;
      for (int c = 1; c <= 21; c++) begin
         @(posedge clk); #1;
         if (done) begin
            ndone++;
            check("b2b_D", d_out, 32'd5);
            if (last >= 0 && (c - last) != K + 1) gap_bad++;
            last = c;
         end
      end
      start = 1'b0;
      check("b2b_count", ndone, 4);
      check("b2b_gap", gap_bad, 0);
      cyc = 0;
      while (!ready && cyc < 30) begin
         @(posedge clk); #1;
         cyc++;
      end
      check("b2b_idle", ready, 1);
      n_vec++;

      // Randomised operands
      for (int i = 0; i < 40; i++) begin
         ra = $urandom;
         case (i % 8)
            0: rb = ra;
            1: rb = ra + 32'd1;
            2: rb = ra >> 3;
            default: rb = $urandom;
         endcase
         do_op(ra, rb);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
